sample_packer: RTL and testbench
================================

Name: sample_packer

Overview:
- Upstream feeder for the pyramid adder tree.
- Gathers SIZE consecutive WIDTH-bit samples from a serial AXI-stream into one SIZE*WIDTH-bit vector, ready to be reduced.
- An early i_tlast closes a short packet: unused lanes are zero-padded so the downstream sum stays correct.
- Reports the count of valid lanes per vector.

Parameters:
- WIDTH, 16, bits per sample.
- SIZE, 3, samples per output vector (≥2).
- CW, $clog2(SIZE+1), width of lane count (derived localparam, not overridable).

Ports:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush, active-high.
- i_tdata  in  WIDTH  input sample.
- i_tlast  in  1  last sample of packet.
- i_tvalid  in  1  input valid.
- i_tready  out  1  input ready.
- o_tdata  out  SIZE*WIDTH  packed vector; lane k at bits [(k+1)*WIDTH-1:k*WIDTH].
- o_tuser  out  CW  number of valid lanes, 1..SIZE.
- o_tlast  out  1  vector closes a packet.
- o_tvalid  out  1  output valid.
- o_tready  in  1  output ready.

Behaviour:
- Reset (reset_n low, async): o_tvalid=0, o_tlast=0, o_tuser=0, o_tdata=0, lane counter=0, gather register=0. All outputs hold these values until the first completed vector.
- clear (sync, priority over handshakes): same state as reset. Discards the partial vector and any held output vector.
- Accept beat: i_tvalid & i_tready.
- i_tready = ~o_tvalid | o_tready | ~completing.
  - completing = (cnt==SIZE-1) | i_tlast.
  - Ready may depend on i_tlast/i_tvalid, never the reverse.
  - o_tvalid never depends on o_tready.
- Gather:
  - Accepted sample is written to lane cnt of the gather register.
  - If not completing, cnt <= cnt+1.
- Complete (accepted completing beat):
  - Output register <= gather register with the current sample inserted at lane cnt.
  - Lanes above cnt are forced to 0 (never stale data).
  - o_tuser <= cnt+1; o_tlast <= i_tlast; o_tvalid <= 1.
  - cnt <= 0; gather register <= 0.
- Latency: output valid 1 cycle after the completing beat. Throughput 1 sample/cycle with o_tready=1.
- Output hold:
  - While o_tvalid & ~o_tready, o_tdata/o_tuser/o_tlast are stable.
  - Non-completing beats are still accepted into the gather register.
  - A completing beat stalls (i_tready=0) until the output drains.
- Simultaneous output drain and new completion in the same cycle: the new vector loads; o_tvalid stays 1 (no bubble).
- Output drain with no new completion: o_tvalid <= 0.
- cnt==SIZE-1 with i_tlast=1: one full vector, o_tuser=SIZE, o_tlast=1.
- Single-sample packet (i_tlast at cnt=0): o_tuser=1, lanes 1..SIZE-1 = 0.
- i_tvalid low: no state change; a partial vector waits indefinitely.
- Mid-operation reset/clear:
  - No vector emitted from the partial data.
  - First post-reset sample lands in lane 0.

Test Plan:
- Stream 1,2,3,4,5,6 (WIDTH=16, SIZE=3, o_tready=1, no tlast) -> vectors {3,2,1} then {6,5,4}; o_tuser=3; each valid 1 cycle after sample 3 and sample 6 respectively.
- Stream 7,8 with tlast on 8 -> o_tdata=0x0000_0008_0007, o_tuser=2, o_tlast=1.
- Hold o_tready=0 after first vector, stream 10,11,12 ->
  - 10 and 11 accepted; i_tready=0 on 12.
  - First vector stable.
  - Raise o_tready: 12 accepted, next vector {12,11,10} valid next cycle.
- Back-to-back completions, o_tready toggling 1/0 -> no lost or duplicated vectors; compare against a scoreboard over 1000 random samples with random tlast.
- Accept 2 samples, pulse clear -> no output. Next 3 samples form a vector starting at lane 0. Repeat with reset_n asserted asynchronously mid-cycle -> outputs 0 immediately.
- Single-beat packet 0xFFFF with tlast -> o_tdata lane0=0xFFFF, lanes 1,2=0, o_tuser=1.

Source files
------------

// File: rtl/sample_packer.sv
// Packs SIZE consecutive AXI-stream samples into one wide vector for the adder tree.
// A short packet (early i_tlast) is zero-padded in the unused upper lanes.
module sample_packer #(
   parameter int WIDTH = 16,
   parameter int SIZE  = 3
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        clear,
   input  logic [WIDTH-1:0]            i_tdata,
   input  logic                        i_tlast,
   input  logic                        i_tvalid,
   output logic                        i_tready,
   output logic [SIZE*WIDTH-1:0]       o_tdata,
   output logic [$clog2(SIZE+1)-1:0]   o_tuser,
   output logic                        o_tlast,
   output logic                        o_tvalid,
   input  logic                        o_tready
);

   localparam int CW = $clog2(SIZE+1);

   logic [CW-1:0]                r_cnt;
   logic [SIZE-1:0][WIDTH-1:0]   r_gather;
   logic [SIZE-1:0][WIDTH-1:0]   r_odata;
   logic [CW-1:0]                r_ouser;
   logic                         r_olast;
   logic                         r_ovalid;

   logic                         w_completing;
   logic                         w_ready;
   logic                         w_accept;
   logic [SIZE-1:0][WIDTH-1:0]   w_merged;

   // Only a completing beat needs a free output slot; partial beats always go in.
   assign w_completing = (r_cnt == CW'(SIZE-1)) | i_tlast;
   assign w_ready      = ~r_ovalid | o_tready | ~w_completing;
   assign w_accept     = i_tvalid & w_ready;

   always_comb begin
      w_merged = '0;
      for (int k = 0; k < SIZE; k++) begin
         if (CW'(k) < r_cnt) begin
            w_merged[k] = r_gather[k];
         end else if (CW'(k) == r_cnt) begin
            w_merged[k] = i_tdata;
         end else begin
            w_merged[k] = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt    <= '0;
         r_gather <= '0;
         r_odata  <= '0;
         r_ouser  <= '0;
         r_olast  <= 1'b0;
         r_ovalid <= 1'b0;
      end else if (clear) begin
         r_cnt    <= '0;
         r_gather <= '0;
         r_odata  <= '0;
         r_ouser  <= '0;
         r_olast  <= 1'b0;
         r_ovalid <= 1'b0;
      end else begin
         // A drain and a fresh completion in one cycle leave r_ovalid set.
         if (o_tready) begin
            r_ovalid <= 1'b0;
         end
         if (w_accept) begin
            if (w_completing) begin
               r_odata  <= w_merged;
               r_ouser  <= r_cnt + CW'(1);
               r_olast  <= i_tlast;
               r_ovalid <= 1'b1;
               r_cnt    <= '0;
               r_gather <= '0;
            end else begin
               for (int k = 0; k < SIZE; k++) begin
                  if (CW'(k) == r_cnt) begin
                     r_gather[k] <= i_tdata;
                  end
               end
               r_cnt <= r_cnt + CW'(1);
            end
         end
      end
   end

   assign i_tready = w_ready;
   assign o_tdata  = r_odata;
   assign o_tuser  = r_ouser;
   assign o_tlast  = r_olast;
   assign o_tvalid = r_ovalid;

endmodule

// File: tb/tb_sample_packer.sv
// Scoreboard bench for sample_packer: directed cases plus a randomized stream with
// random backpressure, checked against a packet-level model kept in queues.
module tb_sample_packer;

   localparam int WIDTH = 16;
   localparam int SIZE  = 3;
   localparam int CW    = $clog2(SIZE+1);

   logic                   clk = 1'b0;
   logic                   reset_n = 1'b0;
   logic                   clear = 1'b0;
   logic [WIDTH-1:0]       i_tdata = '0;
   logic                   i_tlast = 1'b0;
   logic                   i_tvalid = 1'b0;
   logic                   i_tready;
   logic [SIZE*WIDTH-1:0]  o_tdata;
   logic [CW-1:0]          o_tuser;
   logic                   o_tlast;
   logic                   o_tvalid;
   logic                   o_tready = 1'b1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [SIZE*WIDTH-1:0] data;
      logic [CW-1:0]         user;
      logic                  last;
   } vec_t;

   vec_t             expQ[$];
   logic [WIDTH-1:0] partial[$];
   vec_t             heldVec;
   vec_t             popVec;
   vec_t             newVec;
   bit               holdPending = 1'b0;
   bit               randomReady = 1'b0;
   logic             expReady;

   sample_packer #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (clear),
      .i_tdata  (i_tdata),
      .i_tlast  (i_tlast),
      .i_tvalid (i_tvalid),
      .i_tready (i_tready),
      .o_tdata  (o_tdata),
      .o_tuser  (o_tuser),
      .o_tlast  (o_tlast),
      .o_tvalid (o_tvalid),
      .o_tready (o_tready)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Drive one beat from posedge+1 and hold it until a negedge shows ready.
   task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic last);
      bit acc = 1'b0;
      i_tdata  = d;
      i_tlast  = last;
      i_tvalid = 1'b1;
      for (int t = 0; t < 200 && !acc; t++) begin
         @(negedge clk);
         if (i_tready) acc = 1'b1;
         @(posedge clk);
         #1;
      end
      i_tvalid = 1'b0;
      i_tlast  = 1'b0;
      checkOutput("beat_accepted", 64'(acc), 64'd1);
   endtask

   // Monitor: sampled mid-cycle, so every value seen here is what the next edge acts on.
   always @(negedge clk) begin
      if (!reset_n || clear) begin
         expQ.delete();
         partial.delete();
         holdPending = 1'b0;
      end else begin
         if (holdPending) begin
            checkOutput("hold_valid", 64'(o_tvalid), 64'd1);
            checkOutput("hold_data", 64'(o_tdata), 64'(heldVec.data));
            checkOutput("hold_user", 64'(o_tuser), 64'(heldVec.user));
            checkOutput("hold_last", 64'(o_tlast), 64'(heldVec.last));
         end
         expReady = !o_tvalid || o_tready ||
                    !((partial.size() == SIZE-1) || i_tlast);
         checkOutput("in_ready", 64'(i_tready), 64'(expReady));
         if (o_tvalid && o_tready) begin
            checkOutput("vector_expected", 64'(expQ.size() > 0), 64'd1);
            if (expQ.size() > 0) begin
               popVec = expQ.pop_front();
               checkOutput("out_data", 64'(o_tdata), 64'(popVec.data));
               checkOutput("out_user", 64'(o_tuser), 64'(popVec.user));
               checkOutput("out_last", 64'(o_tlast), 64'(popVec.last));
            end
         end
         holdPending  = o_tvalid && !o_tready;
         heldVec.data = o_tdata;
         heldVec.user = o_tuser;
         heldVec.last = o_tlast;
         if (i_tvalid && i_tready) begin
            partial.push_back(i_tdata);
            if (partial.size() == SIZE || i_tlast) begin
               newVec.data = '0;
               foreach (partial[i]) newVec.data[i*WIDTH +: WIDTH] = partial[i];
               newVec.user = CW'(partial.size());
               newVec.last = i_tlast;
               expQ.push_back(newVec);
               partial.delete();
            end
         end
      end
   end

   always begin
      @(posedge clk);
      #1;
      if (randomReady) o_tready = 1'($urandom_range(0, 1));
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired before end of test");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_valid", 64'(o_tvalid), 64'd0);
      checkOutput("reset_data", 64'(o_tdata), 64'd0);
      checkOutput("reset_user", 64'(o_tuser), 64'd0);
      checkOutput("reset_last", 64'(o_tlast), 64'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] full vectors, no backpressure");
      applyStimulus(16'd1, 1'b0);
      applyStimulus(16'd2, 1'b0);
      checkOutput("no_early_valid", 64'(o_tvalid), 64'd0);
      applyStimulus(16'd3, 1'b0);
      checkOutput("vec1_valid", 64'(o_tvalid), 64'd1);
      checkOutput("vec1_data", 64'(o_tdata), 64'h0003_0002_0001);
      checkOutput("vec1_user", 64'(o_tuser), 64'd3);
      applyStimulus(16'd4, 1'b0);
      checkOutput("vec1_drained", 64'(o_tvalid), 64'd0);
      applyStimulus(16'd5, 1'b0);
      applyStimulus(16'd6, 1'b0);
      checkOutput("vec2_data", 64'(o_tdata), 64'h0006_0005_0004);
      checkOutput("vec2_last", 64'(o_tlast), 64'd0);

      $display("[TB] short packet");
      applyStimulus(16'd7, 1'b0);
      applyStimulus(16'd8, 1'b1);
      checkOutput("short_data", 64'(o_tdata), 64'h0000_0008_0007);
      checkOutput("short_user", 64'(o_tuser), 64'd2);
      checkOutput("short_last", 64'(o_tlast), 64'd1);

      $display("[TB] backpressure stall");
      o_tready = 1'b0;
      applyStimulus(16'd10, 1'b0);
      applyStimulus(16'd11, 1'b0);
      i_tdata  = 16'd12;
      i_tlast  = 1'b0;
      i_tvalid = 1'b1;
      @(negedge clk);
      checkOutput("stall_ready", 64'(i_tready), 64'd0);
      checkOutput("stall_hold_data", 64'(o_tdata), 64'h0000_0008_0007);
      @(posedge clk);
      #1;
      o_tready = 1'b1;
      @(negedge clk);
      checkOutput("unstall_ready", 64'(i_tready), 64'd1);
      @(posedge clk);
      #1;
      i_tvalid = 1'b0;
      checkOutput("unstall_valid", 64'(o_tvalid), 64'd1);
      checkOutput("unstall_data", 64'(o_tdata), 64'h000C_000B_000A);
      checkOutput("unstall_user", 64'(o_tuser), 64'd3);

      $display("[TB] synchronous clear");
      applyStimulus(16'd20, 1'b0);
      applyStimulus(16'd21, 1'b0);
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      checkOutput("clear_valid", 64'(o_tvalid), 64'd0);
      applyStimulus(16'd30, 1'b0);
      applyStimulus(16'd31, 1'b0);
      checkOutput("clear_no_partial", 64'(o_tvalid), 64'd0);
      applyStimulus(16'd32, 1'b0);
      checkOutput("clear_next_data", 64'(o_tdata), 64'h0020_001F_001E);

      $display("[TB] asynchronous reset");
      o_tready = 1'b0;
      applyStimulus(16'd40, 1'b0);
      applyStimulus(16'd41, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("areset_valid", 64'(o_tvalid), 64'd0);
      checkOutput("areset_data", 64'(o_tdata), 64'd0);
      checkOutput("areset_user", 64'(o_tuser), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      reset_n  = 1'b1;
      o_tready = 1'b1;
      applyStimulus(16'd50, 1'b0);
      applyStimulus(16'd51, 1'b0);
      checkOutput("areset_no_partial", 64'(o_tvalid), 64'd0);
      applyStimulus(16'd52, 1'b0);
      checkOutput("areset_next_data", 64'(o_tdata), 64'h0034_0033_0032);

      $display("[TB] single-beat packet");
      applyStimulus(16'hFFFF, 1'b1);
      checkOutput("single_data", 64'(o_tdata), 64'h0000_0000_FFFF);
      checkOutput("single_user", 64'(o_tuser), 64'd1);
      checkOutput("single_last", 64'(o_tlast), 64'd1);

      $display("[TB] random stream with random backpressure");
      randomReady = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         applyStimulus(WIDTH'($urandom), 1'($urandom_range(0, 4) == 0));
      end
      applyStimulus(WIDTH'($urandom), 1'b1);
      randomReady = 1'b0;
      @(posedge clk);
      #1;
      o_tready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
      checkOutput("partial_empty", 64'(partial.size()), 64'd0);
      checkOutput("final_valid", 64'(o_tvalid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
